multicycle_control_unit: RTL and testbench

- Multi-cycle sequencer for the RV32I core: fetches an instruction over a valid/ready instruction-memory handshake and latches it into the IR.
- The IR feeds the immediate generator, register file addresses and ALU decoder.
- Steps the instruction through DECODE, EXECUTE, MEM and WRITEBACK, driving every datapath select and write enable.
- Sole owner of PC update, register write and data-memory request timing.

---
 rtl/multicycle_control_unit.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK, owning IR, PC, regfile and dmem timing.
// Outputs are combinational from state, IR and the ready/branch inputs; all strobes are forced low while rst is high.
module multicycle_control_unit #(
  parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  wb_sel,
  output logic        reg_write,
  output logic        instret,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_OP,
    C_OPIMM,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_JALR,
    C_LUI,
    C_AUIPC,
    C_MISC,
    C_SYSTEM,
    C_ILLEGAL
  } iclass_t;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  iclass_t     iclass;

  logic [1:0]  a_sel_c;
  logic        b_sel_c;
  logic [1:0]  wb_sel_c;

  // All listed opcodes end in 2'b11, so compressed encodings fall through to illegal.
  always_comb begin
    iclass = C_ILLEGAL;
    case (ir_q[6:0])
      7'b0110011: iclass = C_OP;
      7'b0010011: iclass = C_OPIMM;
      7'b0000011: iclass = C_LOAD;
      7'b0100011: iclass = C_STORE;
      7'b1100011: iclass = C_BRANCH;
      7'b1101111: iclass = C_JAL;
      7'b1100111: iclass = C_JALR;
      7'b0110111: iclass = C_LUI;
      7'b0010111: iclass = C_AUIPC;
      7'b0001111: iclass = C_MISC;
      7'b1110011: iclass = C_SYSTEM;
      default:    iclass = C_ILLEGAL;
    endcase
  end

  always_comb begin
    a_sel_c  = A_RS1;
    b_sel_c  = 1'b1;
    wb_sel_c = WB_ALU;
    case (iclass)
      C_OP, C_BRANCH: b_sel_c = 1'b0;
      C_LUI:          a_sel_c = A_ZERO;
      C_AUIPC:        a_sel_c = A_PC;
      C_JAL: begin
        a_sel_c  = A_PC;
        wb_sel_c = WB_PC4;
      end
      C_JALR:         wb_sel_c = WB_PC4;
      C_LOAD:         wb_sel_c = WB_LOAD;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = (iclass == C_ILLEGAL) ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        case (iclass)
          C_BRANCH, C_MISC:   state_d = S_FETCH;
          C_SYSTEM, C_ILLEGAL: state_d = S_HALT;
          C_LOAD, C_STORE:    state_d = S_MEM;
          default:            state_d = S_WRITEBACK;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) state_d = (iclass == C_STORE) ? S_FETCH : S_WRITEBACK;
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= RESET_IR;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign ir = ir_q;

  // rst gates every strobe so an in-flight request drops in the reset cycle itself.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    alu_a_sel = A_RS1;
    alu_b_sel = 1'b0;
    wb_sel    = WB_ALU;
    reg_write = 1'b0;
    instret   = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: imem_req = 1'b1;
        S_EXECUTE: begin
          alu_a_sel = a_sel_c;
          alu_b_sel = b_sel_c;
          wb_sel    = wb_sel_c;
          if (iclass == C_BRANCH) begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
            instret  = 1'b1;
          end else if (iclass == C_MISC) begin
            pc_write = 1'b1;
            instret  = 1'b1;
          end
        end
        S_MEM: begin
          alu_a_sel = a_sel_c;
          alu_b_sel = b_sel_c;
          wb_sel    = wb_sel_c;
          dmem_req  = 1'b1;
          dmem_we   = (iclass == C_STORE);
          if (dmem_ready && iclass == C_STORE) begin
            pc_write = 1'b1;
            instret  = 1'b1;
          end
        end
        S_WRITEBACK: begin
          alu_a_sel = a_sel_c;
          alu_b_sel = b_sel_c;
          wb_sel    = wb_sel_c;
          reg_write = 1'b1;
          pc_write  = 1'b1;
          instret   = 1'b1;
          if (iclass == C_JAL)       pc_src = PC_IMM;
          else if (iclass == C_JALR) pc_src = PC_ALU;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: drives one instruction at a time and checks
// per-cycle strobes, selects at retirement, memory-wait latency, halt stickiness and reset abort.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] ir;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel;
  logic [1:0]  wb_sel;
  logic        reg_write;
  logic        instret;
  logic        halted;

  int checks = 0;
  int errors = 0;

  // Results captured by run_instr at the retire (or halt) cycle.
  int         r_cyc, r_imem, r_dmem, r_rw, r_pw;
  logic       r_we, r_halt, r_done;
  logic [1:0] r_pc_src, r_a, r_wb;
  logic       r_b, r_rwr;

  always #5 clk = ~clk;

  multicycle_control_unit #(.RESET_IR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ir(ir),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .branch_taken(branch_taken),
    .pc_write(pc_write), .pc_src(pc_src),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel),
    .reg_write(reg_write), .instret(instret), .halted(halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Starts in FETCH; ready inputs rise after iw / dw wait cycles. Returns one cycle after retire/halt.
  task automatic run_instr(input logic [31:0] instr, input int iw, input int dw, input logic bt);
    r_cyc = 0; r_imem = 0; r_dmem = 0; r_rw = 0; r_pw = 0;
    r_we = 1'b0; r_halt = 1'b0; r_done = 1'b0;
    r_pc_src = 2'd3; r_a = 2'd3; r_wb = 2'd3; r_b = 1'bx; r_rwr = 1'b0;
    for (int cyc = 1; cyc <= 40 && !r_done; cyc++) begin
      imem_rdata   = instr;
      imem_ready   = (r_imem == iw);
      dmem_ready   = (r_dmem == dw);
      branch_taken = bt;
      #1;
      if (imem_req) r_imem++;
      if (dmem_req) begin
        r_dmem++;
        r_we = dmem_we;
      end
      if (reg_write) r_rw++;
      if (pc_write)  r_pw++;
      if (instret || halted) begin
        r_done   = 1'b1;
        r_halt   = halted;
        r_cyc    = cyc;
        r_pc_src = pc_src;
        r_a      = alu_a_sel;
        r_b      = alu_b_sel;
        r_wb     = wb_sel;
        r_rwr    = reg_write;
      end
      tick();
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    checks++;
    if (r_done !== 1'b1) begin
      errors++;
      $display("FAIL timeout instr=%h got no retire/halt within 40 cycles, want retire", instr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({imem_req, dmem_req, dmem_we, pc_write, reg_write, instret, halted} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0000000",
               {imem_req, dmem_req, dmem_we, pc_write, reg_write, instret, halted});
    end
    checks++;
    if (ir !== 32'h0000_0013) begin errors++; $display("FAIL reset_ir got %h want 00000013", ir); end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_fetch_req got %b want 1", imem_req); end
  endtask

  task automatic test_addi();
    do_reset();
    imem_rdata = 32'h0050_0093;
    imem_ready = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL addi_fetch_req got %b want 1", imem_req); end
    tick();
    imem_ready = 1'b0;
    #1;
    checks++;
    if ({imem_req, pc_write, reg_write, instret} !== 4'b0) begin
      errors++; $display("FAIL addi_decode_strobes got %b want 0000", {imem_req, pc_write, reg_write, instret});
    end
    checks++;
    if (ir !== 32'h0050_0093) begin errors++; $display("FAIL addi_ir got %h want 00500093", ir); end
    tick();
    checks++;
    if ({pc_write, reg_write, instret, alu_a_sel, alu_b_sel} !== 6'b000_00_1) begin
      errors++; $display("FAIL addi_execute got %b want 000001", {pc_write, reg_write, instret, alu_a_sel, alu_b_sel});
    end
    tick();
    checks++;
    if ({reg_write, pc_write, pc_src, instret, wb_sel, alu_a_sel, alu_b_sel} !== 10'b1_1_00_1_00_00_1) begin
      errors++; $display("FAIL addi_writeback got %b want 1100100001",
                         {reg_write, pc_write, pc_src, instret, wb_sel, alu_a_sel, alu_b_sel});
    end
    tick();
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL addi_refetch got %b want 1", imem_req); end
  endtask

  task automatic test_load_waits();
    do_reset();
    run_instr(32'h0000_2183, 2, 2, 1'b0);
    checks++;
    if (r_imem !== 3) begin errors++; $display("FAIL lw_imem_cycles got %0d want 3", r_imem); end
    checks++;
    if (r_dmem !== 3 || r_we !== 1'b0) begin
      errors++; $display("FAIL lw_dmem got cycles=%0d we=%b want 3 0", r_dmem, r_we);
    end
    checks++;
    if (r_wb !== 2'd1 || r_rwr !== 1'b1) begin
      errors++; $display("FAIL lw_wb got wb_sel=%0d reg_write=%b want 1 1", r_wb, r_rwr);
    end
    checks++;
    if (r_cyc !== 9) begin errors++; $display("FAIL lw_latency got %0d want 9", r_cyc); end
  endtask

  task automatic test_branch();
    run_instr(32'h0000_0463, 0, 0, 1'b1);
    checks++;
    if (r_cyc !== 3 || r_pc_src !== 2'd1 || r_pw !== 1 || r_rw !== 0) begin
      errors++; $display("FAIL beq_taken got cyc=%0d pc_src=%0d pw=%0d rw=%0d want 3 1 1 0", r_cyc, r_pc_src, r_pw, r_rw);
    end
    run_instr(32'h0000_0463, 0, 0, 1'b0);
    checks++;
    if (r_cyc !== 3 || r_pc_src !== 2'd0 || r_pw !== 1 || r_rw !== 0) begin
      errors++; $display("FAIL beq_not_taken got cyc=%0d pc_src=%0d pw=%0d rw=%0d want 3 0 1 0", r_cyc, r_pc_src, r_pw, r_rw);
    end
  endtask

  task automatic test_jumps();
    run_instr(32'h0001_00E7, 0, 0, 1'b0);
    checks++;
    if ({r_pc_src, r_wb, r_a, r_b, r_rwr} !== 8'b10_10_00_1_1 || r_cyc !== 4) begin
      errors++; $display("FAIL jalr got pc_src=%0d wb=%0d a=%0d b=%b rw=%b cyc=%0d want 2 2 0 1 1 4",
                         r_pc_src, r_wb, r_a, r_b, r_rwr, r_cyc);
    end
    run_instr(32'h0080_00EF, 0, 0, 1'b0);
    checks++;
    if ({r_pc_src, r_wb, r_a, r_b} !== 7'b01_10_01_1 || r_cyc !== 4) begin
      errors++; $display("FAIL jal got pc_src=%0d wb=%0d a=%0d b=%b cyc=%0d want 1 2 1 1 4",
                         r_pc_src, r_wb, r_a, r_b, r_cyc);
    end
  endtask

  task automatic test_back_to_back();
    run_instr(32'h1234_50B7, 0, 0, 1'b0);
    checks++;
    if (r_a !== 2'd2 || r_b !== 1'b1 || r_wb !== 2'd0 || r_cyc !== 4) begin
      errors++; $display("FAIL lui got a=%0d b=%b wb=%0d cyc=%0d want 2 1 0 4", r_a, r_b, r_wb, r_cyc);
    end
    run_instr(32'h0000_000F, 0, 0, 1'b0);
    checks++;
    if (r_cyc !== 3 || r_pc_src !== 2'd0 || r_rw !== 0 || r_pw !== 1) begin
      errors++; $display("FAIL fence got cyc=%0d pc_src=%0d rw=%0d pw=%0d want 3 0 0 1", r_cyc, r_pc_src, r_rw, r_pw);
    end
    run_instr(32'h0011_2023, 0, 0, 1'b0);
    checks++;
    if (r_cyc !== 4 || r_we !== 1'b1 || r_dmem !== 1 || r_rw !== 0 || r_pw !== 1) begin
      errors++; $display("FAIL sw got cyc=%0d we=%b dmem=%0d rw=%0d pw=%0d want 4 1 1 0 1",
                         r_cyc, r_we, r_dmem, r_rw, r_pw);
    end
  endtask

  task automatic test_halt();
    int n_req;
    int n_not_halted;
    do_reset();
    run_instr(32'hFFFF_FFFF, 0, 0, 1'b0);
    checks++;
    if (r_halt !== 1'b1 || r_cyc !== 3) begin
      errors++; $display("FAIL illegal_halt got halted=%b cyc=%0d want 1 3", r_halt, r_cyc);
    end
    n_req = 0;
    n_not_halted = 0;
    imem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (imem_req) n_req++;
      if (halted !== 1'b1) n_not_halted++;
      tick();
    end
    imem_ready = 1'b0;
    checks++;
    if (n_req !== 0 || n_not_halted !== 0) begin
      errors++; $display("FAIL halt_sticky got req_cycles=%0d unhalted_cycles=%0d want 0 0", n_req, n_not_halted);
    end
    do_reset();
    #1;
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_cleared got %b want 0", halted); end
    run_instr(32'h0010_0073, 0, 0, 1'b0);
    checks++;
    if (r_halt !== 1'b1 || r_cyc !== 4 || r_pw !== 0) begin
      errors++; $display("FAIL ebreak_halt got halted=%b cyc=%0d pw=%0d want 1 4 0", r_halt, r_cyc, r_pw);
    end
  endtask

  task automatic test_reset_in_mem();
    do_reset();
    imem_rdata = 32'h0011_2023;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    dmem_ready = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
      errors++; $display("FAIL sw_mem_req got req=%b we=%b want 1 1", dmem_req, dmem_we);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || instret !== 1'b0) begin
      errors++; $display("FAIL rst_drops_dmem got req=%b we=%b instret=%b want 0 0 0", dmem_req, dmem_we, instret);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ir !== 32'h0000_0013 || imem_req !== 1'b1 || halted !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL rst_mem_recover got ir=%h imem_req=%b halted=%b dmem_req=%b want 00000013 1 0 0",
                         ir, imem_req, halted, dmem_req);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_waits();
    test_branch();
    test_jumps();
    test_back_to_back();
    test_halt();
    test_reset_in_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
